// File: rtl/strip_allocator_if.sv
// strip_allocator_if: request/result bundle between a placement client and the strip allocator.
interface strip_allocator_if;
    logic       valid_in;
    logic       ready_out;
    logic [7:0] width_in;
    logic [4:0] height_in;
    logic       valid_out;
    logic [3:0] strip_ID_out;
    logic [7:0] occupied_width_out;
    logic [3:0] strike_out;
    logic       strike_flag_out;
    modport slave (
        input  valid_in, width_in, height_in,
        output ready_out, valid_out, strip_ID_out, occupied_width_out, strike_out, strike_flag_out
    );
    modport master (
        output valid_in, width_in, height_in,
        input  ready_out, valid_out, strip_ID_out, occupied_width_out, strike_out, strike_flag_out
    );
endinterface

// File: rtl/strip_allocator.sv
// strip_allocator: best-fit horizontal strip selection on the 128x128 canvas.
// Scans one strip per cycle, tracks per-strip occupied width and counts failed placements.
module strip_allocator #(
    parameter int NUM_STRIPS = 13,
    parameter int CANVAS_W   = 128,
    parameter int MAX_H      = 16
) (
    input logic             clk,
    input logic             rst,
    strip_allocator_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SCAN, RESULT} state_t;
    localparam logic [4:0] HT [NUM_STRIPS] = '{5'd8, 5'd8, 5'd9, 5'd7, 5'd10, 5'd6, 5'd11, 5'd5, 5'd12, 5'd4, 5'd16, 5'd16, 5'd16};
    state_t     r_state, w_next;
    logic [7:0] r_occ [NUM_STRIPS];
    logic [7:0] r_w, r_x;
    logic [4:0] r_h, r_best_h;
    logic [3:0] r_idx, r_best, r_strip, r_strike;
    logic       r_bad, r_flag;
    logic [3:0] w_slot, w_bslot;
    logic       w_fit, w_better, w_commit;
    // r_idx runs one past the last strip: that extra cycle commits the chosen placement
    always_comb begin
        w_slot   = (r_idx != 4'd0 && r_idx <= 4'(NUM_STRIPS)) ? r_idx - 4'd1 : 4'd0;
        w_bslot  = (r_best != 4'd0) ? r_best - 4'd1 : 4'd0;
        w_fit    = r_state == SCAN && r_idx != 4'd0 && r_idx <= 4'(NUM_STRIPS) && !r_bad &&
                   r_h <= HT[w_slot] && ({1'b0, r_occ[w_slot]} + {1'b0, r_w} <= 9'(CANVAS_W));
        w_better = w_fit && (r_best == 4'd0 || HT[w_slot] < r_best_h);
        w_commit = r_state == SCAN && r_idx == 4'(NUM_STRIPS + 1);
        w_next   = r_state;
        case (r_state)
            IDLE:    w_next = bus.valid_in ? SCAN : IDLE;
            SCAN:    w_next = w_commit ? RESULT : SCAN;
            default: w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_w      <= '0;
            r_h      <= '0;
            r_bad    <= 1'b0;
            r_idx    <= '0;
            r_best   <= '0;
            r_best_h <= '0;
            r_strip  <= '0;
            r_x      <= '0;
            r_strike <= '0;
            r_flag   <= 1'b0;
            for (int i = 0; i < NUM_STRIPS; i++) r_occ[i] <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && bus.valid_in) begin
                r_w    <= bus.width_in;
                r_h    <= bus.height_in;
                r_bad  <= bus.width_in == 8'd0 || bus.width_in > 8'(CANVAS_W) ||
                          bus.height_in == 5'd0 || bus.height_in > 5'(MAX_H);
                r_idx  <= 4'd1;
                r_best <= 4'd0;
            end
            if (r_state == SCAN) r_idx <= r_idx + 4'd1;
            if (w_better) begin
                r_best   <= r_idx;
                r_best_h <= HT[w_slot];
            end
            if (w_commit) begin
                r_strip <= r_best;
                r_x     <= (r_best != 4'd0) ? r_occ[w_bslot] : 8'd0;
                r_flag  <= r_best == 4'd0;
                if (r_best != 4'd0) r_occ[w_bslot] <= r_occ[w_bslot] + r_w;
                else if (r_strike != 4'd15) r_strike <= r_strike + 4'd1;
            end
        end
    end
    assign bus.ready_out          = r_state == IDLE;
    assign bus.valid_out          = r_state == RESULT;
    assign bus.strip_ID_out       = r_strip;
    assign bus.occupied_width_out = r_x;
    assign bus.strike_out         = r_strike;
    assign bus.strike_flag_out    = r_flag;
endmodule
